// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO between the UART receiver and the bus/software reader.
// Show-ahead valid/ready read port, occupancy/almost-full status, sticky overrun with drop counter.
module uart_rx_fifo #(
    parameter int BYTE_WIDTH   = 8,
    parameter int DEPTH        = 16,
    parameter int AFULL_THRESH = 12
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rx_done,
    input  logic [BYTE_WIDTH-1:0]      data_in,
    input  logic                       rd_ready,
    output logic                       rd_valid,
    output logic [BYTE_WIDTH-1:0]      rd_data,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       almost_full,
    output logic                       overrun,
    output logic [7:0]                 drop_count,
    input  logic                       overrun_clr
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [BYTE_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic                  full;
    logic                  push;
    logic                  pop;
    logic                  drop;

    // A full FIFO still accepts a byte when a pop frees a slot in the same cycle.
    assign full     = (level == LVL_W'(DEPTH));
    assign rd_valid = (level != '0);
    assign pop      = rd_valid && rd_ready;
    assign push     = rx_done && (!full || pop);
    assign drop     = rx_done && !push;

    assign rd_data     = rd_valid ? mem[rd_ptr] : '0;
    assign almost_full = (level >= LVL_W'(AFULL_THRESH));

    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                level <= level + LVL_W'(1);
            end else if (pop && !push) begin
                level <= level - LVL_W'(1);
            end
        end
    end

    // A drop in the same cycle as a clear wins, restarting the count at one.
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun    <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            overrun <= 1'b1;
            if (overrun_clr) begin
                drop_count <= 8'd1;
            end else if (drop_count != 8'hFF) begin
                drop_count <= drop_count + 8'd1;
            end
        end else if (overrun_clr) begin
            overrun    <= 1'b0;
            drop_count <= '0;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: a directed vector table plus hand-written
// sequences for fill/drain, overrun saturation, full-with-pop, wrap-around and reset.
module tb_uart_rx_fifo;

    logic       clk;
    logic       rst;
    logic       rx_done;
    logic [7:0] data_in;
    logic       rd_ready;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic [4:0] level;
    logic       almost_full;
    logic       overrun;
    logic [7:0] drop_count;
    logic       overrun_clr;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       rst;
        logic       rx_done;
        logic [7:0] data_in;
        logic       rd_ready;
        logic       overrun_clr;
        logic       exp_valid;
        logic [7:0] exp_data;
        logic [4:0] exp_level;
        logic       exp_afull;
        logic       exp_overrun;
        logic [7:0] exp_drops;
    } vec_t;

    vec_t vecs [10];

    uart_rx_fifo #(
        .BYTE_WIDTH  (8),
        .DEPTH       (16),
        .AFULL_THRESH(12)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_done    (rx_done),
        .data_in    (data_in),
        .rd_ready   (rd_ready),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .level      (level),
        .almost_full(almost_full),
        .overrun    (overrun),
        .drop_count (drop_count),
        .overrun_clr(overrun_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkField(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Inputs change 1 ns after the edge, so outputs are read well away from it.
    task automatic applyStimulus(input logic r, input logic rx, input logic [7:0] d,
                                 input logic rdy, input logic clr);
        rst         = r;
        rx_done     = rx;
        data_in     = d;
        rd_ready    = rdy;
        overrun_clr = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic ev, input logic [7:0] ed,
                               input logic [4:0] el, input logic eaf, input logic eov,
                               input logic [7:0] edc);
        checkField({name, ".rd_valid"},    32'(rd_valid),    32'(ev));
        checkField({name, ".rd_data"},     32'(rd_data),     32'(ed));
        checkField({name, ".level"},       32'(level),       32'(el));
        checkField({name, ".almost_full"}, 32'(almost_full), 32'(eaf));
        checkField({name, ".overrun"},     32'(overrun),     32'(eov));
        checkField({name, ".drop_count"},  32'(drop_count),  32'(edc));
    endtask

    initial begin
        logic [7:0] q [$];
        logic [7:0] exp_byte;
        logic       rdy;

        rst = 1'b1; rx_done = 1'b0; data_in = 8'h00; rd_ready = 1'b0; overrun_clr = 1'b0;

        //          rst rx  data   rdy clr   valid data  lvl af ov drops
        vecs[0] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0, 1'b0, 8'd0};
        vecs[1] = '{1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 8'hA5, 5'd1, 1'b0, 1'b0, 8'd0};
        vecs[2] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0, 1'b0, 8'd0};
        vecs[3] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0, 1'b0, 8'd0};
        vecs[4] = '{1'b0, 1'b1, 8'h11, 1'b1, 1'b0, 1'b1, 8'h11, 5'd1, 1'b0, 1'b0, 8'd0};
        vecs[5] = '{1'b0, 1'b1, 8'h22, 1'b1, 1'b0, 1'b1, 8'h22, 5'd1, 1'b0, 1'b0, 8'd0};
        vecs[6] = '{1'b0, 1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 8'h22, 5'd2, 1'b0, 1'b0, 8'd0};
        vecs[7] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h33, 5'd1, 1'b0, 1'b0, 8'd0};
        vecs[8] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h33, 5'd1, 1'b0, 1'b0, 8'd0};
        vecs[9] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0, 1'b0, 8'd0};

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].rx_done, vecs[i].data_in, vecs[i].rd_ready,
                          vecs[i].overrun_clr);
            checkOutput($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_data,
                        vecs[i].exp_level, vecs[i].exp_afull, vecs[i].exp_overrun,
                        vecs[i].exp_drops);
        end

        // Fill to full; head stays at 0x00 and almost_full rises at level 12.
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, 1'b1, 8'(i), 1'b0, 1'b0);
            checkOutput($sformatf("fill%0d", i), 1'b1, 8'h00, 5'(i + 1), (i + 1) >= 12,
                        1'b0, 8'd0);
        end

        // Drops while full: count saturates at 255, contents untouched.
        for (int n = 1; n <= 300; n++) begin
            applyStimulus(1'b0, 1'b1, 8'h77, 1'b0, 1'b0);
            checkOutput($sformatf("drop%0d", n), 1'b1, 8'h00, 5'd16, 1'b1, 1'b1,
                        (n > 255) ? 8'd255 : 8'(n));
        end
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput("clr", 1'b1, 8'h00, 5'd16, 1'b1, 1'b0, 8'd0);

        // Full with simultaneous pop: 0x5A is accepted, nothing dropped.
        applyStimulus(1'b0, 1'b1, 8'h5A, 1'b1, 1'b0);
        checkOutput("full_pop", 1'b1, 8'h01, 5'd16, 1'b1, 1'b0, 8'd0);
        for (int k = 0; k < 16; k++) begin
            exp_byte = (k < 15) ? 8'(k + 1) : 8'h5A;
            checkField($sformatf("drainA%0d.rd_data", k), 32'(rd_data), 32'(exp_byte));
            checkField($sformatf("drainA%0d.level", k), 32'(level), 32'(16 - k));
            applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        end
        checkOutput("drainA_end", 1'b0, 8'h00, 5'd0, 1'b0, 1'b0, 8'd0);

        // Drop coinciding with overrun_clr: the set wins.
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, 1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
        end
        checkOutput("refill", 1'b1, 8'h80, 5'd16, 1'b1, 1'b0, 8'd0);
        applyStimulus(1'b0, 1'b1, 8'h99, 1'b0, 1'b1);
        checkOutput("drop_clr", 1'b1, 8'h80, 5'd16, 1'b1, 1'b1, 8'd1);
        for (int k = 0; k < 16; k++) begin
            checkField($sformatf("drainB%0d.rd_data", k), 32'(rd_data), 32'(8'h80 + k));
            applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        end
        checkOutput("drainB_end", 1'b0, 8'h00, 5'd0, 1'b0, 1'b1, 8'd1);

        // 20 pushes with a pop every third cycle, crossing the pointer wrap.
        for (int i = 0; i < 20; i++) begin
            rdy = (i % 3 == 2);
            if (rdy && q.size() > 0) void'(q.pop_front());
            q.push_back(8'(8'hC0 + i));
            applyStimulus(1'b0, 1'b1, 8'(8'hC0 + i), rdy, 1'b0);
            checkOutput($sformatf("wrap%0d", i), 1'b1, q[0], 5'(q.size()), q.size() >= 12,
                        1'b1, 8'd1);
        end
        while (q.size() > 7) begin
            void'(q.pop_front());
            applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
            checkOutput($sformatf("part%0d", q.size()), 1'b1, q[0], 5'(q.size()),
                        q.size() >= 12, 1'b1, 8'd1);
        end

        // Reset at level 7 with a byte arriving in the same cycle.
        applyStimulus(1'b1, 1'b1, 8'hEE, 1'b0, 1'b0);
        checkOutput("rst_mid", 1'b0, 8'h00, 5'd0, 1'b0, 1'b0, 8'd0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("post_rst", 1'b0, 8'h00, 5'd0, 1'b0, 1'b0, 8'd0);
        applyStimulus(1'b0, 1'b1, 8'h42, 1'b0, 1'b0);
        checkOutput("post_rst_push", 1'b1, 8'h42, 5'd1, 1'b0, 1'b0, 8'd0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("post_rst_pop", 1'b0, 8'h00, 5'd0, 1'b0, 1'b0, 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
